axi_wr_arb: RTL

AXI_WR_ARB -- requirements
Module: axi_wr_arb

---
 rtl/axi_wr_arb.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/axi_wr_arb.sv
// axi_wr_arb: two-master AXI3 write-channel arbiter.
//
// Purpose
//   Merges two write masters onto one AXI write port. m0 carries write-buffer
//   line flushes, m1 carries uncached dcache writes. One burst at a time owns
//   the AW/W channels. Bursts whose B response is still pending are counted
//   and limited to MAX_OUTST. B responses are routed back by bid[0].
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   mN_aw* / mN_awready       AW request of master N (N = 0, 1)
//   mN_w*  / mN_wready        W data of master N
//   mN_bresp/bvalid, mN_bready  B response to master N
//   aw* / awready             AXI AW channel (awid = {3'b000, grant})
//   w*  / wready              AXI W channel  (wid  = {3'b000, grant})
//   bid/bresp/bvalid, bready  AXI B channel
//   awlock/awcache/awprot     constant 0
//   idle                      no burst in progress and none outstanding
module axi_wr_arb #(
   parameter int MAX_OUTST = 2
) (
   input  logic        clk,
   input  logic        rstn,
   // master 0: write-buffer flushes
   input  logic [31:0] m0_awaddr,
   input  logic [3:0]  m0_awlen,
   input  logic [2:0]  m0_awsize,
   input  logic [1:0]  m0_awburst,
   input  logic        m0_awvalid,
   output logic        m0_awready,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   input  logic        m0_wlast,
   input  logic        m0_wvalid,
   output logic        m0_wready,
   output logic [1:0]  m0_bresp,
   output logic        m0_bvalid,
   input  logic        m0_bready,
   // master 1: uncached dcache writes
   input  logic [31:0] m1_awaddr,
   input  logic [3:0]  m1_awlen,
   input  logic [2:0]  m1_awsize,
   input  logic [1:0]  m1_awburst,
   input  logic        m1_awvalid,
   output logic        m1_awready,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   input  logic        m1_wlast,
   input  logic        m1_wvalid,
   output logic        m1_wready,
   output logic [1:0]  m1_bresp,
   output logic        m1_bvalid,
   input  logic        m1_bready,
   // AXI write address channel
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   // AXI write data channel
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   // AXI write response channel
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready,
   // status
   output logic        idle
);

   localparam int CNT_W = $clog2(MAX_OUTST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t           state_q;
   logic             grant_q;
   logic             last_grant_q;
   logic [CNT_W-1:0] outst_q;
   logic [CNT_W-1:0] outst_d;

   logic any_req;
   logic winner;
   logic can_issue;
   logic in_addr;
   logic in_data;
   logic aw_hs;
   logic wlast_hs;
   logic b_hs;
   logic unused_bid;

   assign in_addr = (state_q == ADDR);
   assign in_data = (state_q == DATA);

   // Arbitration: a lone requester wins; on a tie the master not granted
   // last time wins.
   always_comb begin
      any_req   = m0_awvalid | m1_awvalid;
      can_issue = (outst_q < MAX_CNT);
      if (m0_awvalid && m1_awvalid) begin
         winner = ~last_grant_q;
      end else begin
         winner = m1_awvalid;
      end
   end

   // AW channel: granted master passes through only while in ADDR.
   assign awid    = {3'b000, grant_q};
   assign awaddr  = grant_q ? m1_awaddr  : m0_awaddr;
   assign awlen   = grant_q ? m1_awlen   : m0_awlen;
   assign awsize  = grant_q ? m1_awsize  : m0_awsize;
   assign awburst = grant_q ? m1_awburst : m0_awburst;
   assign awvalid = in_addr & (grant_q ? m1_awvalid : m0_awvalid);
   assign m0_awready = in_addr & ~grant_q & awready;
   assign m1_awready = in_addr &  grant_q & awready;
   assign awlock  = 2'b00;
   assign awcache = 4'b0000;
   assign awprot  = 3'b000;

   // W channel: granted master passes through only while in DATA.
   assign wid    = {3'b000, grant_q};
   assign wdata  = grant_q ? m1_wdata : m0_wdata;
   assign wstrb  = grant_q ? m1_wstrb : m0_wstrb;
   assign wlast  = grant_q ? m1_wlast : m0_wlast;
   assign wvalid = in_data & (grant_q ? m1_wvalid : m0_wvalid);
   assign m0_wready = in_data & ~grant_q & wready;
   assign m1_wready = in_data &  grant_q & wready;

   // B channel: steered by bid[0] regardless of FSM state. bvalid toward the
   // masters is held off while reset is asserted; bready still follows the
   // selected master.
   assign m0_bvalid = rstn & bvalid & ~bid[0];
   assign m1_bvalid = rstn & bvalid &  bid[0];
   assign m0_bresp  = bresp;
   assign m1_bresp  = bresp;
   assign bready    = bid[0] ? m1_bready : m0_bready;
   assign unused_bid = ^bid[3:1];

   assign aw_hs    = awvalid & awready;
   assign wlast_hs = wvalid & wready & wlast;
   assign b_hs     = bvalid & bready;

   // Outstanding-burst counter; simultaneous AW and B handshakes cancel, and
   // a stray B response never drives it below zero.
   always_comb begin
      outst_d = outst_q;
      if (aw_hs && !b_hs) begin
         outst_d = outst_q + 1'b1;
      end else if (b_hs && !aw_hs && (outst_q != '0)) begin
         outst_d = outst_q - 1'b1;
      end
   end

   assign idle = (state_q == IDLE) && (outst_q == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         outst_q      <= '0;
      end else begin
         outst_q <= outst_d;
         case (state_q)
            IDLE: begin
               if (any_req && can_issue) begin
                  grant_q      <= winner;
                  last_grant_q <= winner;
                  state_q      <= ADDR;
               end
            end
            // grant is held here even if the master drops awvalid early
            ADDR: begin
               if (aw_hs) begin
                  state_q <= DATA;
               end
            end
            // returning to IDLE forces one bubble cycle before the next grant
            DATA: begin
               if (wlast_hs) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
